tour_cmd: RTL and testbench

Replays a computed knight's tour as motion commands for the command processor. Sits between the tour solver (upstream; supplies one one-hot move per index) and `cmd_proc` (downstream). Muxes between the UART command path and its own tour commands, and selects the response byte sent back through the UART. While idle it is transparent to the UART path; during a tour it owns `cmd`/`cmd_rdy` for 24 moves × 2 commands.

---
 rtl/tour_pkg.sv | 37 +++
 rtl/knight_move_dec.sv | 53 +++++
 rtl/tour_cmd.sv | 99 +++++++++
 tb/tb_tour_cmd.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command replayer.
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERT,
    HOLD_V,
    HORZ,
    HOLD_H
  } tour_state_t;

  // Command opcodes
  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_MOVE_FF = 4'h3;

  // Headings
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  // Response bytes
  localparam logic [7:0] POS_ACK  = 8'hA5;
  localparam logic [7:0] TOUR_ACK = 8'h5A;

  // Index of the final move of a 24-move tour
  localparam logic [4:0] LAST_MOVE = 5'd23;

  // Pack a command word as {opcode, heading, squares}
  function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                           input logic [7:0] hdg,
                                           input logic [3:0] sq);
    return {op, hdg, sq};
  endfunction

endpackage

// File: rtl/knight_move_dec.sv
// Decodes a one-hot knight move into its vertical and horizontal legs.
// The lowest set bit wins; an all-zero move decodes as bit 0.
module knight_move_dec
  import tour_pkg::*;
(
  input  logic [7:0]  mv_q,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  // Isolate the lowest set bit (two's-complement trick)
  logic [7:0] lsb_oh;
  assign lsb_oh = mv_q & (~mv_q + 8'd1);

  // Map the winning move bit to a vertical leg and a horizontal leg
  always_comb begin
    // Bit 0 (+1,+2) is also the fallback for an empty move
    vert_cmd = make_cmd(OP_MOVE,    HDG_N, 4'd2);
    horz_cmd = make_cmd(OP_MOVE_FF, HDG_E, 4'd1);
    case (lsb_oh)
      8'h02: begin  // (-1,+2)
        vert_cmd = make_cmd(OP_MOVE,    HDG_N, 4'd2);
        horz_cmd = make_cmd(OP_MOVE_FF, HDG_W, 4'd1);
      end
      8'h04: begin  // (-2,+1)
        vert_cmd = make_cmd(OP_MOVE,    HDG_N, 4'd1);
        horz_cmd = make_cmd(OP_MOVE_FF, HDG_W, 4'd2);
      end
      8'h08: begin  // (-2,-1)
        vert_cmd = make_cmd(OP_MOVE,    HDG_S, 4'd1);
        horz_cmd = make_cmd(OP_MOVE_FF, HDG_W, 4'd2);
      end
      8'h10: begin  // (-1,-2)
        vert_cmd = make_cmd(OP_MOVE,    HDG_S, 4'd2);
        horz_cmd = make_cmd(OP_MOVE_FF, HDG_W, 4'd1);
      end
      8'h20: begin  // (+1,-2)
        vert_cmd = make_cmd(OP_MOVE,    HDG_S, 4'd2);
        horz_cmd = make_cmd(OP_MOVE_FF, HDG_E, 4'd1);
      end
      8'h40: begin  // (+2,-1)
        vert_cmd = make_cmd(OP_MOVE,    HDG_S, 4'd1);
        horz_cmd = make_cmd(OP_MOVE_FF, HDG_E, 4'd2);
      end
      8'h80: begin  // (+2,+1)
        vert_cmd = make_cmd(OP_MOVE,    HDG_N, 4'd1);
        horz_cmd = make_cmd(OP_MOVE_FF, HDG_E, 4'd2);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as motion commands, muxed with the UART
// command path. Transparent to the UART while idle.
module tour_cmd
  import tour_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp
);

  tour_state_t state_reg, state_next;
  logic [4:0]  mv_indx_reg, mv_indx_next;
  logic [7:0]  mv_q_reg, mv_q_next;
  logic [15:0] vert_cmd, horz_cmd;

  knight_move_dec u_dec (
    .mv_q     (mv_q_reg),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd)
  );

  // State, move index and latched move registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mv_indx_reg <= 5'd0;
      mv_q_reg    <= 8'd0;
    end else begin
      state_reg   <= state_next;
      mv_indx_reg <= mv_indx_next;
      mv_q_reg    <= mv_q_next;
    end
  end

  // Next-state logic plus the cmd/cmd_rdy/resp output mux
  always_comb begin
    state_next   = state_reg;
    mv_indx_next = mv_indx_reg;
    mv_q_next    = mv_q_reg;
    cmd          = vert_cmd;
    cmd_rdy      = 1'b0;
    resp         = TOUR_ACK;
    case (state_reg)
      IDLE: begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = POS_ACK;
        if (start_tour) begin
          mv_indx_next = 5'd0;
          state_next   = LOAD;
        end
      end
      LOAD: begin
        // The solver has had one cycle to present move[mv_indx]
        mv_q_next  = move;
        state_next = VERT;
      end
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_next = HOLD_V;
      end
      HOLD_V: begin
        cmd = vert_cmd;
        if (send_resp) state_next = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_next = HOLD_H;
      end
      HOLD_H: begin
        cmd = horz_cmd;
        if (mv_indx_reg == LAST_MOVE) resp = POS_ACK;
        if (send_resp) begin
          if (mv_indx_reg == LAST_MOVE) begin
            state_next = IDLE;
          end else begin
            mv_indx_next = mv_indx_reg + 5'd1;
            state_next   = LOAD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mv_indx = mv_indx_reg;

endmodule

// File: tb/tb_tour_cmd.sv
// Scoreboard bench for tour_cmd: stimulus pushes expected commands,
// a monitor pops and compares on every rising cmd_rdy.
module tb_tour_cmd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  always #5 clk = ~clk;

  tour_cmd dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .resp         (resp)
  );

  // Solver stub: combinational lookup of the move table
  logic [7:0] mv_table [24];
  always_comb move = (mv_indx < 5'd24) ? mv_table[mv_indx] : 8'h00;

  // Hand-computed command pairs per winning move bit
  logic [15:0] exp_v [8] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1,
                             16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
  logic [15:0] exp_h [8] = '{16'h3BF1, 16'h33F1, 16'h33F2, 16'h33F2,
                             16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};

  // Full tour: moves (some multi-bit / zero) and their hand-derived winning bit
  logic [7:0] tour_b [24] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h00, 8'h06, 8'hC0, 8'hFF, 8'h18, 8'hA0, 8'h80, 8'h44,
                              8'h30, 8'h03, 8'h60, 8'h90, 8'h48, 8'h22, 8'h84, 8'hC0};
  int tour_b_bit [24] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 6, 0,
                          3, 5, 7, 2, 4, 0, 5, 4, 3, 1, 2, 6};

  typedef struct packed {
    logic [15:0] cmd;
    logic [4:0]  idx;
  } exp_t;
  exp_t exp_q [$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_exp(input logic [15:0] c, input logic [4:0] i);
    exp_t e;
    e.cmd = c;
    e.idx = i;
    exp_q.push_back(e);
  endtask

  // Monitor: every new command presented is checked against the scoreboard
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_rdy === 1'b1 && !prev) begin
        exp_t e;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_cmd: got %h expected none", cmd);
        end else begin
          e = exp_q.pop_front();
          check("cmd", {16'h0, cmd}, {16'h0, e.cmd});
          check("cmd_mv_indx", {27'h0, mv_indx}, {27'h0, e.idx});
          $display("cmd %h at mv_indx %0d (expected %h)", cmd, mv_indx, e.cmd);
        end
      end
      prev = (cmd_rdy === 1'b1);
    end
  end

  // cmd_proc stub: accept the pending command, check the hold phase, then respond
  task automatic serve(input logic [7:0] exp_resp, input bit both, input bit do_send);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_rdy === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk_cnt++;
      $display("FAIL cmd_rdy_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b1;
    send_resp = both;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    @(negedge clk);
    check("hold_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("hold_resp", {24'h0, resp}, {24'h0, exp_resp});
    if (do_send) begin
      @(posedge clk);
      #1 send_resp = 1'b1;
      @(posedge clk);
      #1 send_resp = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    start_tour   = 1'b0;
    cmd_UART     = 16'h0000;
    cmd_rdy_UART = 1'b0;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    for (int i = 0; i < 24; i++) mv_table[i] = 8'h01;
    mv_table[1] = 8'h10;
    mv_table[2] = 8'h04;

    // Reset values
    @(negedge clk);
    check("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("rst_resp", {24'h0, resp}, 32'hA5);
    check("rst_mv_indx", {27'h0, mv_indx}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // IDLE passthrough of the UART command
    cmd_UART = 16'h7010;
    push_exp(16'h7010, 5'd0);
    cmd_rdy_UART = 1'b1;
    @(negedge clk);
    check("idle_cmd_rdy", {31'h0, cmd_rdy}, 32'h1);
    check("idle_resp", {24'h0, resp}, 32'hA5);

    // Tour A: start_tour together with a UART command
    for (int i = 0; i < 3; i++) begin
      push_exp(exp_v[i == 0 ? 0 : (i == 1 ? 4 : 2)], 5'(i));
      push_exp(exp_h[i == 0 ? 0 : (i == 1 ? 4 : 2)], 5'(i));
    end
    @(posedge clk);
    #1 start_tour = 1'b1;
    @(negedge clk);
    check("start_cycle_cmd", {16'h0, cmd}, 32'h7010);
    check("start_cycle_cmd_rdy", {31'h0, cmd_rdy}, 32'h1);
    @(posedge clk);
    #1 start_tour = 1'b0;
    cmd_rdy_UART = 1'b0;
    cmd_UART = 16'h0000;
    @(negedge clk);
    check("load_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("load_mv_indx", {27'h0, mv_indx}, 32'h0);
    check("load_resp", {24'h0, resp}, 32'h5A);
    for (int i = 0; i < 3; i++) begin
      serve(8'h5A, (i == 1), 1'b1);
      serve(8'h5A, 1'b0, 1'b1);
    end

    // Move 3: UART activity and a stray start_tour must be ignored
    push_exp(16'h2002, 5'd3);
    push_exp(16'h3BF1, 5'd3);
    cmd_UART = 16'hDEAD;
    cmd_rdy_UART = 1'b1;
    serve(8'h5A, 1'b0, 1'b1);
    @(posedge clk);
    #1 start_tour = 1'b1;
    @(posedge clk);
    #1 start_tour = 1'b0;
    @(negedge clk);
    check("horz_start_ignored_cmd", {16'h0, cmd}, 32'h3BF1);
    serve(8'h5A, 1'b0, 1'b1);
    for (int i = 4; i < 7; i++) begin
      push_exp(16'h2002, 5'(i));
      push_exp(16'h3BF1, 5'(i));
      serve(8'h5A, 1'b0, 1'b1);
      serve(8'h5A, 1'b0, 1'b1);
    end
    push_exp(16'h2002, 5'd7);
    serve(8'h5A, 1'b0, 1'b0);

    // Abort in HOLD_V at move 7
    check("abort_mv_indx_pre", {27'h0, mv_indx}, 32'h7);
    push_exp(16'hDEAD, 5'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_mv_indx", {27'h0, mv_indx}, 32'h0);
    check("abort_cmd_rdy", {31'h0, cmd_rdy}, 32'h1);
    check("abort_cmd", {16'h0, cmd}, 32'hDEAD);
    check("abort_resp", {24'h0, resp}, 32'hA5);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cmd_rdy_UART = 1'b0;
    @(negedge clk);
    check("abort_idle_follow", {31'h0, cmd_rdy}, 32'h0);

    // Tour B: full 24-move replay
    for (int i = 0; i < 24; i++) mv_table[i] = tour_b[i];
    for (int i = 0; i < 24; i++) begin
      push_exp(exp_v[tour_b_bit[i]], 5'(i));
      push_exp(exp_h[tour_b_bit[i]], 5'(i));
    end
    @(posedge clk);
    #1 start_tour = 1'b1;
    @(posedge clk);
    #1 start_tour = 1'b0;
    for (int i = 0; i < 24; i++) begin
      serve(8'h5A, 1'b0, 1'b1);
      serve((i == 23) ? 8'hA5 : 8'h5A, 1'b0, 1'b1);
    end
    @(negedge clk);
    check("end_mv_indx", {27'h0, mv_indx}, 32'd23);
    check("end_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("end_resp", {24'h0, resp}, 32'hA5);

    // Back in IDLE: UART passthrough again
    cmd_UART = 16'h1234;
    push_exp(16'h1234, 5'd23);
    cmd_rdy_UART = 1'b1;
    repeat (2) @(negedge clk);
    check("post_idle_cmd", {16'h0, cmd}, 32'h1234);
    check("scoreboard_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
